// File: rtl/pwm_capture_if.sv
// Result port of the PWM capture block: one-deep valid/ready measurement record.
// master = capture block (producer), slave = bus bridge (consumer).
interface pwm_capture_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 io_result_valid;
    logic                 io_result_ready;
    logic [CNT_WIDTH-1:0] io_result_high;
    logic [CNT_WIDTH-1:0] io_result_period;
    logic                 io_result_overflow;
    logic                 io_result_level;

    modport master (
        output io_result_valid,
        input  io_result_ready,
        output io_result_high,
        output io_result_period,
        output io_result_overflow,
        output io_result_level
    );

    modport slave (
        input  io_result_valid,
        output io_result_ready,
        input  io_result_high,
        input  io_result_period,
        input  io_result_overflow,
        input  io_result_level
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and rise-to-rise period of io_pwm_pin
// in io_mainClk cycles and presents each measurement in a one-deep result register.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | capture disabled, counters cleared
// WAIT_RISE | armed, waiting for the first rising edge (nothing counted)
// HIGH      | counting the high phase of the current period
// LOW       | counting the low phase; next rise publishes the period
module pwm_capture #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic              io_mainClk,
    input  logic              io_resetn,
    input  logic              io_pwm_pin,
    input  logic              io_enable,
    input  logic              io_clear,
    output logic              io_overrun,
    pwm_capture_if.master     result
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    generate
        if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
            $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 sync_out;
    logic                 level;
    logic                 level_q;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hi_len;

    logic                 publish;
    logic [CNT_WIDTH-1:0] pub_high;
    logic [CNT_WIDTH-1:0] pub_period;
    logic                 pub_overflow;
    logic                 pub_level;

    logic                 res_valid;
    logic [CNT_WIDTH-1:0] res_high;
    logic [CNT_WIDTH-1:0] res_period;
    logic                 res_overflow;
    logic                 res_level;
    logic                 overrun;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pwm_pin};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] filt_cnt;

    // Accept a new level only after FILTER_LEN consecutive samples agree; both edges see the same delay.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            filt_cnt <= '0;
            level    <= 1'b0;
        end else if (sync_out == level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            level    <= sync_out;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    assign level = sync_out;
`endif

    // Registered edge pulses on the conditioned level.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
        end
    end

    // Capture FSM: counters and phase tracking; a stall sends it back to WAIT_RISE so it reports once.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn || !io_enable) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state  <= LOW;
                        hi_len <= cnt;
                        // Saturate so a fall on the last count still reports as a stall next cycle.
                        cnt    <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        state <= WAIT_RISE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        state <= WAIT_RISE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decide whether this cycle produces a measurement or a stall report.
    always_comb begin
        publish      = 1'b0;
        pub_high     = hi_len;
        pub_period   = cnt;
        pub_overflow = 1'b0;
        if (io_enable) begin
            case (state)
                HIGH: begin
                    if (!fall && cnt == CNT_MAX) begin
                        publish      = 1'b1;
                        pub_high     = CNT_MAX;
                        pub_period   = CNT_MAX;
                        pub_overflow = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        publish      = 1'b1;
                        pub_high     = CNT_MAX;
                        pub_period   = CNT_MAX;
                        pub_overflow = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        pub_level = pub_overflow & level;
    end

    // One-deep result register with sticky overrun; a discard wins over a same-cycle clear.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            res_valid    <= 1'b0;
            res_high     <= '0;
            res_period   <= '0;
            res_overflow <= 1'b0;
            res_level    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (publish && (!res_valid || result.io_result_ready)) begin
                res_valid    <= 1'b1;
                res_high     <= pub_high;
                res_period   <= pub_period;
                res_overflow <= pub_overflow;
                res_level    <= pub_level;
            end else if (res_valid && result.io_result_ready) begin
                res_valid <= 1'b0;
            end
            if (publish && res_valid && !result.io_result_ready) overrun <= 1'b1;
            else if (io_clear)                                  overrun <= 1'b0;
        end
    end

    assign result.io_result_valid    = res_valid;
    assign result.io_result_high     = res_high;
    assign result.io_result_period   = res_period;
    assign result.io_result_overflow = res_overflow;
    assign result.io_result_level    = res_level;
    assign io_overrun                = overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of pulse trains plus hand sequences
// for backpressure, stall overflow, enable drop, glitches and reset during capture.
module tb_pwm_capture;

    localparam int CNT_WIDTH   = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = SYNC_STAGES + 2 + FILTER_LEN;
`else
    localparam int LAT = SYNC_STAGES + 2;
`endif
    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pin = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic overrun;

    pwm_capture_if #(.CNT_WIDTH(CNT_WIDTH)) rif();

    pwm_capture #(
        .CNT_WIDTH  (CNT_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .io_mainClk(clk),
        .io_resetn (resetn),
        .io_pwm_pin(pin),
        .io_enable (enable),
        .io_clear  (clear),
        .io_overrun(overrun),
        .result    (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_WIDTH-1:0] high;
        logic [CNT_WIDTH-1:0] period;
        logic                 ovf;
        logic                 level;
    } exp_t;

    typedef struct {
        int pin_high;
        int pin_low;
        int exp_high;
        int exp_period;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int p, input logic o, input logic l);
        exp_t e;
        e.high   = CNT_WIDTH'(h);
        e.period = CNT_WIDTH'(p);
        e.ovf    = o;
        e.level  = l;
        exp_q.push_back(e);
    endtask

    task automatic pin_period(input int h, input int p);
        pin = 1'b1;
        repeat (h) tick();
        pin = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic start_segment;
        pin = 1'b0;
        enable = 1'b0;
        repeat (LAT + 4) tick();
        enable = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Consumer side: every handshake pops the next expected result.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && rif.io_result_valid && rif.io_result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got high=%0d period=%0d ovf=%0d, required no result",
                         rif.io_result_high, rif.io_result_period, rif.io_result_overflow);
            end else begin
                e = exp_q.pop_front();
                check("result_high", rif.io_result_high, e.high);
                check("result_period", rif.io_result_period, e.period);
                check("result_overflow", rif.io_result_overflow, e.ovf);
                check("result_level", rif.io_result_level, e.level);
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{25, 75, 25, 100};
        vecs[1] = '{50, 10, 50, 60};
        vecs[2] = '{10, 190, 10, 200};
        vecs[3] = '{4, 4, 4, 8};
        vecs[4] = '{96, 4, 96, 100};
        vecs[5] = '{5, 4, 5, 9};
        rif.io_result_ready = 1'b1;

        // Reset with the pin toggling
        resetn = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            pin = ((i / 3) % 2) == 1;
            tick();
        end
        check("reset_valid", rif.io_result_valid, 0);
        check("reset_high", rif.io_result_high, 0);
        check("reset_period", rif.io_result_period, 0);
        check("reset_overflow", rif.io_result_overflow, 0);
        check("reset_level", rif.io_result_level, 0);
        check("reset_overrun", overrun, 0);
        pin = 1'b0;
        repeat (LAT + 2) tick();
        resetn = 1'b1;
        repeat (2) tick();
        pin = 1'b1;
        repeat (30) tick();
        check("no_valid_after_one_rise", rif.io_result_valid, 0);
        pin = 1'b0;
        repeat (70) tick();
        push(30, 100, 1'b0, 1'b0);
        pin = 1'b1;
        wait_drain("drain_first");

        // Table of pulse trains, then rise-to-valid latency on the closing rise
        start_segment();
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < 2; r++) begin
                push(vecs[i].exp_high, vecs[i].exp_period, 1'b0, 1'b0);
                pin_period(vecs[i].pin_high, vecs[i].pin_high + vecs[i].pin_low);
            end
        end
        pin = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rif.io_result_valid && n < 40);
        check("rise_to_valid_latency", n, LAT);
        wait_drain("drain_table");

        // Backpressure: hold first result, discards set overrun
        start_segment();
        rif.io_result_ready = 1'b0;
        push(30, 100, 1'b0, 1'b0);
        pin_period(30, 100);
        pin_period(40, 100);
        pin_period(50, 100);
        check("held_valid", rif.io_result_valid, 1);
        check("held_high", rif.io_result_high, 30);
        check("held_period", rif.io_result_period, 100);
        check("overrun_set", overrun, 1);
        // Discard and clear in the same cycle: overrun stays set
        pin = 1'b1;
        repeat (LAT - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("overrun_discard_beats_clear", overrun, 1);
        repeat (20 - LAT) tick();
        pin = 1'b0;
        repeat (40) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("overrun_cleared", overrun, 0);
        repeat (39) tick();
        // Consume old result in the same cycle a new one is published
        push(20, 100, 1'b0, 1'b0);
        pin = 1'b1;
        repeat (LAT - 1) tick();
        rif.io_result_ready = 1'b1;
        tick();
        check("valid_after_swap", rif.io_result_valid, 1);
        check("no_overrun_on_swap", overrun, 0);
        wait_drain("drain_backpressure");

        // Stuck high line: exactly one overflow report, then normal capture resumes
        start_segment();
        push(ALL_ONES, ALL_ONES, 1'b1, 1'b1);
        pin = 1'b1;
        repeat (70000) tick();
        check("overflow_reported", exp_q.size(), 0);
        pin = 1'b0;
        repeat (50) tick();
        push(25, 100, 1'b0, 1'b0);
        pin_period(25, 100);
        pin = 1'b1;
        wait_drain("drain_after_overflow");

        // Enable dropped mid-high: broken period is not reported
        start_segment();
        pin = 1'b1;
        repeat (15) tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (10) tick();
        pin = 1'b0;
        repeat (75) tick();
        push(30, 100, 1'b0, 1'b0);
        pin_period(30, 100);
        pin = 1'b1;
        wait_drain("drain_enable_drop");

        // Two-cycle low glitch inside a 25-cycle high phase
        start_segment();
`ifdef PWM_CAPTURE_FILTER_EN
        push(25, 100, 1'b0, 1'b0);
`else
        push(10, 12, 1'b0, 1'b0);
        push(13, 88, 1'b0, 1'b0);
`endif
        pin = 1'b1;
        repeat (10) tick();
        pin = 1'b0;
        repeat (2) tick();
        pin = 1'b1;
        repeat (13) tick();
        pin = 1'b0;
        repeat (75) tick();
        push(25, 100, 1'b0, 1'b0);
        pin_period(25, 100);
        pin = 1'b1;
        wait_drain("drain_glitch");

        // Reset while a result is held and overrun is set
        start_segment();
        rif.io_result_ready = 1'b0;
        pin_period(30, 100);
        pin_period(30, 100);
        pin = 1'b1;
        repeat (LAT + 2) tick();
        check("pre_reset_valid", rif.io_result_valid, 1);
        check("pre_reset_overrun", overrun, 1);
        resetn = 1'b0;
        tick();
        check("mid_reset_valid", rif.io_result_valid, 0);
        check("mid_reset_high", rif.io_result_high, 0);
        check("mid_reset_period", rif.io_result_period, 0);
        check("mid_reset_overrun", overrun, 0);
        pin = 1'b0;
        repeat (LAT + 2) tick();
        resetn = 1'b1;
        rif.io_result_ready = 1'b1;
        tick();
        pin = 1'b1;
        repeat (40) tick();
        check("no_valid_after_reset_rise", rif.io_result_valid, 0);
        pin = 1'b0;
        repeat (60) tick();
        push(40, 100, 1'b0, 1'b0);
        pin = 1'b1;
        wait_drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
